xram_arbiter: RTL and testbench

Two-port arbiter and strobe sequencer for the external 64K×16 asynchronous SRAM on the drm65 system bus. It shares the SRAM between the CPU (port 0) and a secondary master (port 1, video/DMA). It turns byte-wide requests into the SRAM's active-low OE/WE/BLE/BHE strobe sequence with a programmable strobe width, and returns read data with a single-cycle acknowledge.

---
 rtl/xram_pkg.sv | 22 ++
 rtl/xram_arbiter_if.sv | 45 ++++
 rtl/xram_rr_grant.sv | 37 +++
 rtl/xram_arbiter.sv | 133 +++++++++++++
 tb/tb_xram_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xram_pkg.sv
// Shared types and constants for the external SRAM arbiter: FSM state encoding,
// byte-lane select values, strobe counter width and the read-lane mux helper.
package xram_pkg;

   localparam int STROBE_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      STROBE  = 2'd2,
      RECOVER = 2'd3
   } xram_state_e;

   // Byte address bit 0 picks the SRAM lane.
   localparam logic LANE_LO = 1'b0;
   localparam logic LANE_HI = 1'b1;

   function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
      return (lane == LANE_HI) ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/xram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the external SRAM.
// slave = arbiter side, master = requesters plus the SRAM data return path.
interface xram_arbiter_if;

   logic        p0_req;
   logic        p0_we;
   logic [16:0] p0_addr;
   logic [7:0]  p0_wdata;
   logic [7:0]  p0_rdata;
   logic        p0_ack;

   logic        p1_req;
   logic        p1_we;
   logic [16:0] p1_addr;
   logic [7:0]  p1_wdata;
   logic [7:0]  p1_rdata;
   logic        p1_ack;

   logic [15:0] xa;
   logic [7:0]  xdo;
   logic [15:0] xdi;
   logic        xoe;
   logic        xwe;
   logic        xble;
   logic        xbhe;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      output p0_rdata, p0_ack,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      output p1_rdata, p1_ack,
      output xa, xdo, xoe, xwe, xble, xbhe,
      input  xdi
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      input  p0_rdata, p0_ack,
      output p1_req, p1_we, p1_addr, p1_wdata,
      input  p1_rdata, p1_ack,
      input  xa, xdo, xoe, xwe, xble, xbhe,
      output xdi
   );

endinterface

// File: rtl/xram_rr_grant.sv
// Winner select for the two SRAM requesters. Build with XRAM_ARB_RR_EN defined
// for round-robin on ties; otherwise port 0 has fixed priority.
module xram_rr_grant (
   input  logic clk,
   input  logic reset,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_take,
   output logic o_any,
   output logic o_gnt
);

   assign o_any = i_req0 | i_req1;

`ifdef XRAM_ARB_RR_EN
   logic r_last;
   logic w_gnt;

   // On a tie the port not served last wins; reset value 1 hands port 0 the first tie.
   assign w_gnt = (i_req0 && i_req1) ? ~r_last : i_req1;
   assign o_gnt = w_gnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last <= 1'b1;
      end else if (i_take) begin
         r_last <= w_gnt;
      end
   end
`else
   logic w_unused;

   assign o_gnt    = ~i_req0 & i_req1;
   assign w_unused = &{1'b0, clk, reset, i_take};
`endif

endmodule

// File: rtl/xram_arbiter.sv
// Two-port arbiter and OE/WE/BLE/BHE strobe sequencer for the 64Kx16 async SRAM.
// Arbitration mode is chosen inside xram_rr_grant (macro XRAM_ARB_RR_EN).
module xram_arbiter
   import xram_pkg::*;
#(
   parameter int unsigned STROBE_CYC = 2
) (
   input  logic           clk,
   input  logic           reset,
   xram_arbiter_if.slave  bus
);

   localparam logic [STROBE_CNT_W-1:0] STROBE_LOAD = STROBE_CNT_W'(STROBE_CYC - 1);

   xram_state_e             r_state;
   logic [STROBE_CNT_W-1:0] r_cnt;
   logic                    r_gnt;
   logic                    r_we;
   logic                    r_lane;
   logic [15:0]             r_xa;
   logic [7:0]              r_xdo;
   logic                    r_xoe;
   logic                    r_xwe;
   logic                    r_xble;
   logic                    r_xbhe;
   logic                    r_ack0;
   logic                    r_ack1;
   logic [7:0]              r_rdata0;
   logic [7:0]              r_rdata1;

   logic                    w_any;
   logic                    w_gnt;
   logic                    w_take;
   logic                    w_we;
   logic [16:0]             w_addr;
   logic [7:0]              w_wdata;
   logic [7:0]              w_rbyte;

   assign w_take = (r_state == IDLE) && w_any;

   xram_rr_grant u_grant (
      .clk    (clk),
      .reset  (reset),
      .i_req0 (bus.p0_req),
      .i_req1 (bus.p1_req),
      .i_take (w_take),
      .o_any  (w_any),
      .o_gnt  (w_gnt)
   );

   assign w_we    = w_gnt ? bus.p1_we    : bus.p0_we;
   assign w_addr  = w_gnt ? bus.p1_addr  : bus.p0_addr;
   assign w_wdata = w_gnt ? bus.p1_wdata : bus.p0_wdata;
   assign w_rbyte = lane_byte(bus.xdi, r_lane);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_gnt    <= 1'b0;
         r_we     <= 1'b0;
         r_lane   <= LANE_LO;
         r_xa     <= '0;
         r_xdo    <= '0;
         r_xoe    <= 1'b1;
         r_xwe    <= 1'b1;
         r_xble   <= 1'b1;
         r_xbhe   <= 1'b1;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         // NOTE: acks default low every cycle so a single set in STROBE yields a one-cycle pulse.
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt   <= w_gnt;
                  r_we    <= w_we;
                  r_lane  <= w_addr[0];
                  r_xa    <= w_addr[16:1];
                  r_xdo   <= w_wdata;
                  r_xble  <= w_addr[0];
                  r_xbhe  <= ~w_addr[0];
                  r_state <= SETUP;
               end
            end
            SETUP: begin
               r_xwe   <= ~r_we;
               r_xoe   <= r_we;
               r_cnt   <= STROBE_LOAD;
               r_state <= STROBE;
            end
            STROBE: begin
               if (r_cnt == '0) begin
                  r_xoe   <= 1'b1;
                  r_xwe   <= 1'b1;
                  r_state <= RECOVER;
                  if (r_gnt) r_ack1 <= 1'b1;
                  else       r_ack0 <= 1'b1;
                  // xdi is still driven at this edge because xoe releases on it.
                  if (!r_we) begin
                     if (r_gnt) r_rdata1 <= w_rbyte;
                     else       r_rdata0 <= w_rbyte;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RECOVER: begin
               r_xble  <= 1'b1;
               r_xbhe  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.xa       = r_xa;
   assign bus.xdo      = r_xdo;
   assign bus.xoe      = r_xoe;
   assign bus.xwe      = r_xwe;
   assign bus.xble     = r_xble;
   assign bus.xbhe     = r_xbhe;
   assign bus.p0_ack   = r_ack0;
   assign bus.p1_ack   = r_ack1;
   assign bus.p0_rdata = r_rdata0;
   assign bus.p1_rdata = r_rdata1;

endmodule

// File: tb/tb_xram_arbiter.sv
// Directed bench for xram_arbiter: main instance at STROBE_CYC=2 with an SRAM model,
// plus STROBE_CYC=1 and 15 instances for strobe-width and ack-latency limits.
module tb_xram_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   xram_arbiter_if bus ();
   xram_arbiter_if bus1 ();
   xram_arbiter_if bus15 ();

   xram_arbiter #(.STROBE_CYC(2))  u_dut   (.clk(clk), .reset(reset), .bus(bus));
   xram_arbiter #(.STROBE_CYC(1))  u_dut1  (.clk(clk), .reset(reset), .bus(bus1));
   xram_arbiter #(.STROBE_CYC(15)) u_dut15 (.clk(clk), .reset(reset), .bus(bus15));

   logic [15:0] mem [0:65535];

   // Asynchronous SRAM: data only while OE is low, byte writes while WE is low.
   assign bus.xdi   = bus.xoe ? 16'hDEAD : mem[bus.xa];
   assign bus1.xdi  = 16'h0000;
   assign bus15.xdi = 16'h0000;

   always @(posedge clk) begin
      if (!bus.xwe) begin
         if (!bus.xble) mem[bus.xa][7:0]  <= bus.xdo;
         if (!bus.xbhe) mem[bus.xa][15:8] <= bus.xdo;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;
   int order[$];

   task automatic drive(input int port, input logic req, input logic we,
                        input logic [16:0] addr, input logic [7:0] wd);
      if (port == 0) begin
         bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
      end else begin
         bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
      end
   endtask

   // Starts at a negedge inside an IDLE cycle; returns at the negedge of the following IDLE cycle.
   task automatic access(input int port, input logic we, input logic [16:0] addr,
                         input logic [7:0] wd, output int ack_at, output int lows,
                         output logic [15:0] xa_s, output logic [1:0] lanes_s,
                         output logic ovl);
      logic ack;
      drive(port, 1'b1, we, addr, wd);
      ack_at = 0; lows = 0; ovl = 1'b0; xa_s = '0; lanes_s = '0;
      for (int k = 1; k <= 30 && ack_at == 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            xa_s    = bus.xa;
            lanes_s = {bus.xbhe, bus.xble};
         end
         if (we ? !bus.xwe : !bus.xoe) lows++;
         if (!bus.xoe && !bus.xwe) ovl = 1'b1;
         ack = (port == 0) ? bus.p0_ack : bus.p1_ack;
         if (ack) ack_at = k;
      end
      drive(port, 1'b0, we, addr, wd);
      @(negedge clk);
   endtask

   task automatic requester(input int port, input int n);
      int t;
      logic ack;
      for (int k = 0; k < n; k++) begin
         drive(port, 1'b1, 1'b0, (port == 0) ? 17'h00012 : 17'h00013, 8'h00);
         t = 0;
         ack = 1'b0;
         while (!ack && t < 200) begin
            @(negedge clk);
            t++;
            ack = (port == 0) ? bus.p0_ack : bus.p1_ack;
         end
         if (!ack) begin
            n_cmp++; n_bad++;
            $display("FAIL arb_timeout port%0d: no ack within 200 cycles", port);
         end
         order.push_back(port);
         drive(port, 1'b0, 1'b0, 17'h0, 8'h00);
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      drive(0, 1'b0, 1'b0, 17'h0, 8'h00);
      drive(1, 1'b0, 1'b0, 17'h0, 8'h00);
      bus1.p0_req = 0;  bus1.p0_we = 0;  bus1.p0_addr = '0;  bus1.p0_wdata = '0;
      bus1.p1_req = 0;  bus1.p1_we = 0;  bus1.p1_addr = '0;  bus1.p1_wdata = '0;
      bus15.p0_req = 0; bus15.p0_we = 0; bus15.p0_addr = '0; bus15.p0_wdata = '0;
      bus15.p1_req = 0; bus15.p1_we = 0; bus15.p1_addr = '0; bus15.p1_wdata = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.xoe, bus.xwe, bus.xble, bus.xbhe} !== 4'hF) begin
         n_bad++; $display("FAIL rst_strobes: got %b expected 1111", {bus.xoe, bus.xwe, bus.xble, bus.xbhe});
      end
      n_cmp++;
      if (bus.xa !== 16'h0000) begin
         n_bad++; $display("FAIL rst_xa: got %h expected 0000", bus.xa);
      end
      n_cmp++;
      if (bus.xdo !== 8'h00) begin
         n_bad++; $display("FAIL rst_xdo: got %h expected 00", bus.xdo);
      end
      n_cmp++;
      if ({bus.p0_ack, bus.p1_ack} !== 2'b00) begin
         n_bad++; $display("FAIL rst_ack: got %b expected 00", {bus.p0_ack, bus.p1_ack});
      end
      n_cmp++;
      if ({bus.p0_rdata, bus.p1_rdata} !== 16'h0000) begin
         n_bad++; $display("FAIL rst_rdata: got %h expected 0000", {bus.p0_rdata, bus.p1_rdata});
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write;
      int ack_at, lows;
      logic [15:0] xa_s;
      logic [1:0] lanes;
      logic ovl;
      access(0, 1'b1, 17'h00012, 8'h34, ack_at, lows, xa_s, lanes, ovl);
      access(0, 1'b1, 17'h00013, 8'h5A, ack_at, lows, xa_s, lanes, ovl);
      n_cmp++;
      if (xa_s !== 16'h0009) begin
         n_bad++; $display("FAIL wr_xa: got %h expected 0009", xa_s);
      end
      n_cmp++;
      if (lanes !== 2'b01) begin
         n_bad++; $display("FAIL wr_lanes {bhe,ble}: got %b expected 01", lanes);
      end
      n_cmp++;
      if (lows !== 2) begin
         n_bad++; $display("FAIL wr_xwe_width: got %0d expected 2", lows);
      end
      n_cmp++;
      if (ack_at !== 4) begin
         n_bad++; $display("FAIL wr_ack_cycle: got N+%0d expected N+4", ack_at);
      end
      n_cmp++;
      if (ovl !== 1'b0) begin
         n_bad++; $display("FAIL wr_oe_we_overlap: got %b expected 0", ovl);
      end
      n_cmp++;
      if (mem[9] !== 16'h5A34) begin
         n_bad++; $display("FAIL wr_mem9: got %h expected 5a34", mem[9]);
      end
   endtask

   task automatic test_read;
      int ack_at, lows;
      logic [15:0] xa_s;
      logic [1:0] lanes;
      logic ovl;
      access(0, 1'b0, 17'h00012, 8'h00, ack_at, lows, xa_s, lanes, ovl);
      n_cmp++;
      if (bus.p0_rdata !== 8'h34) begin
         n_bad++; $display("FAIL rd_p0_low: got %h expected 34", bus.p0_rdata);
      end
      access(0, 1'b1, 17'h00012, 8'h5A, ack_at, lows, xa_s, lanes, ovl);
      access(0, 1'b1, 17'h00013, 8'hA5, ack_at, lows, xa_s, lanes, ovl);
      access(1, 1'b0, 17'h00012, 8'h00, ack_at, lows, xa_s, lanes, ovl);
      n_cmp++;
      if (bus.p1_rdata !== 8'h5A) begin
         n_bad++; $display("FAIL rd_p1_low: got %h expected 5a", bus.p1_rdata);
      end
      n_cmp++;
      if (lows !== 2 || ack_at !== 4) begin
         n_bad++; $display("FAIL rd_timing: got oe_width=%0d ack=N+%0d expected 2 and N+4", lows, ack_at);
      end
      access(1, 1'b0, 17'h00013, 8'h00, ack_at, lows, xa_s, lanes, ovl);
      n_cmp++;
      if (bus.p1_rdata !== 8'hA5) begin
         n_bad++; $display("FAIL rd_p1_high: got %h expected a5", bus.p1_rdata);
      end
      n_cmp++;
      if (bus.p0_rdata !== 8'h34) begin
         n_bad++; $display("FAIL rd_p0_hold: got %h expected 34", bus.p0_rdata);
      end
      access(1, 1'b1, 17'h00016, 8'h11, ack_at, lows, xa_s, lanes, ovl);
      n_cmp++;
      if (bus.p1_rdata !== 8'hA5) begin
         n_bad++; $display("FAIL rd_p1_after_write: got %h expected a5", bus.p1_rdata);
      end
   endtask

   task automatic test_arbitration;
      int exp_order[4];
`ifdef XRAM_ARB_RR_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      order.delete();
      fork
         requester(0, 4);
         requester(1, 4);
      join
      n_cmp++;
      if (order.size() != 8) begin
         n_bad++; $display("FAIL arb_count: got %0d expected 8", order.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= order.size()) begin
            n_bad++; $display("FAIL arb_grant%0d: got none expected %0d", i, exp_order[i]);
         end else if (order[i] != exp_order[i]) begin
            n_bad++; $display("FAIL arb_grant%0d: got %0d expected %0d", i, order[i], exp_order[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      int setups[$];
      int acks = 0;
      logic prev_idle = 1'b1;
      logic setup;
      drive(0, 1'b1, 1'b0, 17'h00012, 8'h00);
      for (int k = 1; k <= 40 && acks < 3; k++) begin
         @(negedge clk);
         setup = (!bus.xble || !bus.xbhe) && bus.xoe && bus.xwe && prev_idle;
         if (setup) setups.push_back(k);
         prev_idle = bus.xble && bus.xbhe;
         if (bus.p0_ack) begin
            acks++;
            if (acks == 1) drive(0, 1'b1, 1'b0, 17'h00013, 8'h00);
            else if (acks == 2) drive(0, 1'b1, 1'b0, 17'h00016, 8'h00);
            else drive(0, 1'b0, 1'b0, 17'h0, 8'h00);
         end
      end
      drive(0, 1'b0, 1'b0, 17'h0, 8'h00);
      @(negedge clk);
      n_cmp++;
      if (setups.size() != 3) begin
         n_bad++; $display("FAIL b2b_setups: got %0d expected 3", setups.size());
      end else begin
         n_cmp++;
         if (setups[1] - setups[0] != 5 || setups[2] - setups[1] != 5) begin
            n_bad++; $display("FAIL b2b_spacing: got %0d,%0d expected 5,5",
                              setups[1] - setups[0], setups[2] - setups[1]);
         end
      end
      n_cmp++;
      if (bus.p0_rdata !== 8'h11) begin
         n_bad++; $display("FAIL b2b_last_read: got %h expected 11", bus.p0_rdata);
      end
   endtask

   task automatic test_reset_mid;
      int ack_at, lows, bad_cycles;
      logic [15:0] xa_s;
      logic [1:0] lanes;
      logic ovl;
      drive(0, 1'b1, 1'b1, 17'h00014, 8'h77);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.xwe !== 1'b0) begin
         n_bad++; $display("FAIL rmid_in_strobe: got xwe=%b expected 0", bus.xwe);
      end
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 17'h0, 8'h00);
      @(negedge clk);
      n_cmp++;
      if ({bus.xoe, bus.xwe, bus.xble, bus.xbhe, bus.p0_ack} !== 5'b11110) begin
         n_bad++; $display("FAIL rmid_strobes_ack: got %b expected 11110",
                           {bus.xoe, bus.xwe, bus.xble, bus.xbhe, bus.p0_ack});
      end
      reset = 1'b0;
      bad_cycles = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.p0_ack || !bus.xwe || !bus.xoe) bad_cycles++;
      end
      n_cmp++;
      if (bad_cycles != 0) begin
         n_bad++; $display("FAIL rmid_quiet: got %0d active cycles expected 0", bad_cycles);
      end
      n_cmp++;
      if (bus.p0_rdata !== 8'h00) begin
         n_bad++; $display("FAIL rmid_rdata_cleared: got %h expected 00", bus.p0_rdata);
      end
      access(0, 1'b0, 17'h00014, 8'h00, ack_at, lows, xa_s, lanes, ovl);
      n_cmp++;
      if (ack_at !== 4 || bus.p0_rdata !== 8'h77) begin
         n_bad++; $display("FAIL rmid_after: got ack=N+%0d data=%h expected N+4 and 77", ack_at, bus.p0_rdata);
      end
   endtask

   task automatic test_strobe_width;
      int lows, ack_at;
      bus1.p0_we = 1; bus1.p0_addr = 17'h00004; bus1.p0_wdata = 8'h3C; bus1.p0_req = 1;
      lows = 0; ack_at = 0;
      for (int k = 1; k <= 40 && ack_at == 0; k++) begin
         @(negedge clk);
         if (!bus1.xwe) lows++;
         if (bus1.p0_ack) ack_at = k;
      end
      bus1.p0_req = 0;
      @(negedge clk);
      n_cmp++;
      if (lows !== 1) begin
         n_bad++; $display("FAIL sw1_width: got %0d expected 1", lows);
      end
      n_cmp++;
      if (ack_at !== 3) begin
         n_bad++; $display("FAIL sw1_ack: got N+%0d expected N+3", ack_at);
      end
      bus15.p0_we = 1; bus15.p0_addr = 17'h00005; bus15.p0_wdata = 8'hC3; bus15.p0_req = 1;
      lows = 0; ack_at = 0;
      for (int k = 1; k <= 40 && ack_at == 0; k++) begin
         @(negedge clk);
         if (!bus15.xwe) lows++;
         if (bus15.p0_ack) ack_at = k;
      end
      bus15.p0_req = 0;
      @(negedge clk);
      n_cmp++;
      if (lows !== 15) begin
         n_bad++; $display("FAIL sw15_width: got %0d expected 15", lows);
      end
      n_cmp++;
      if (ack_at !== 17) begin
         n_bad++; $display("FAIL sw15_ack: got N+%0d expected N+17", ack_at);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_arbitration();
      test_back_to_back();
      test_reset_mid();
      test_strobe_width();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
